// File: rtl/fp_pkg.sv
// Shared floating-point definitions: field widths, bias, rounding modes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

  localparam int EXP_W  = 8;    // IEEE754 single exponent field
  localparam int MAN_W  = 23;   // IEEE754 single fraction field
  localparam int EXPI_W = 10;   // signed working exponent, wide enough for a-b+bias
  localparam int BIAS   = 127;

  localparam logic [1:0] RM_RNE = 2'b00;  // nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'b01;  // toward zero
  localparam logic [1:0] RM_RUP = 2'b10;  // toward +inf
  localparam logic [1:0] RM_RDN = 2'b11;  // toward -inf

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_round.sv
// GRS rounding of a normalized significand: decide increment, add, renormalize on carry.
// Latency: purely combinational.
// Backpressure: none; caller registers the outputs.
module fp_round
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic [1:0]        rounding_mode,
  input  logic [MAN_W-1:0]  mant_in,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  input  logic [EXPI_W-1:0] exp_in,
  output logic [MAN_W-1:0]  mant_out,
  output logic [EXP_W-1:0]  exp_field
);

  logic             inc;
  logic [MAN_W+1:0] sum;  // {carry, hidden, fraction}

  // Increment decision from guard/round/sticky and the requested direction
  always_comb begin
    inc = 1'b0;
    if ({g, r, s} != 3'b000) begin
      case (rounding_mode)
        RM_RNE:  inc = g & (r | s | mant_in[0]);
        RM_RTZ:  inc = 1'b0;
        RM_RUP:  inc = ~sign;
        default: inc = sign;
      endcase
    end
  end

  // Add the increment to the full significand; a carry out renormalizes by one
  always_comb begin
    sum = {1'b0, 1'b1, mant_in} + {{(MAN_W + 1){1'b0}}, inc};
    if (sum[MAN_W+1]) begin
      mant_out  = sum[MAN_W:1];
      exp_field = EXP_W'(exp_in + EXPI_W'(1));
    end else begin
      mant_out  = sum[MAN_W-1:0];
      exp_field = EXP_W'(exp_in);
    end
  end

endmodule

// File: rtl/fp_divider.sv
// IEEE754 single divider: restoring radix-2 iteration, one quotient bit per cycle, then GRS round.
// Latency: result valid ITER+2 edges after accept; divide-by-zero result valid 1 edge after accept.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until the cycle after the output handshake.
module fp_divider
  import fp_pkg::*;
#(
  parameter int ITER = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [1:0]  rounding_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero
);

  localparam int CW = $clog2(ITER);

  state_t            state;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [1:0]        rm_q;
  logic              unpacked;   // first DIV cycle unpacks operands and screens a zero divisor
  logic [CW-1:0]     cnt;
  logic [ITER-1:0]   quot;
  logic [MAN_W+1:0]  rem;        // partial remainder, always < 2*divisor significand
  logic [MAN_W:0]    dsr;        // divisor significand with hidden bit

  logic [MAN_W+2:0]  diff;
  logic              ge;
  logic [MAN_W+1:0]  rem_nx;

  logic              res_sign;
  logic [EXPI_W-1:0] exp_raw;
  logic [EXPI_W-1:0] exp_norm;
  logic [MAN_W-1:0]  n_man;
  logic              n_g;
  logic              n_r;
  logic              n_s;
  logic [MAN_W-1:0]  rnd_man;
  logic [EXP_W-1:0]  rnd_exp;

  // Single trial subtraction: keep the difference when it does not borrow
  always_comb begin
    diff   = {1'b0, rem} - {2'b00, dsr};
    ge     = ~diff[MAN_W+2];
    rem_nx = ge ? diff[MAN_W+1:0] : rem;
  end

  // Sign, biased exponent and quotient normalization into mantissa plus G/R/S
  always_comb begin
    res_sign = a_q[31] ^ b_q[31];
    exp_raw  = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + EXPI_W'(BIAS);
    if (quot[ITER-1]) begin
      n_man    = quot[ITER-2 -: MAN_W];
      n_g      = quot[2];
      n_r      = quot[1];
      n_s      = quot[0] | (|rem);
      exp_norm = exp_raw;
    end else begin
      n_man    = quot[ITER-3 -: MAN_W];
      n_g      = quot[1];
      n_r      = quot[0];
      n_s      = |rem;
      exp_norm = exp_raw - EXPI_W'(1);
    end
  end

  fp_round u_round (
    .sign          (res_sign),
    .rounding_mode (rm_q),
    .mant_in       (n_man),
    .g             (n_g),
    .r             (n_r),
    .s             (n_s),
    .exp_in        (exp_norm),
    .mant_out      (rnd_man),
    .exp_field     (rnd_exp)
  );

  // Control FSM with registered handshake outputs and the iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= RM_RNE;
      unpacked    <= 1'b0;
      cnt         <= '0;
      quot        <= '0;
      rem         <= '0;
      dsr         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= dividend;
            b_q      <= divisor;
            rm_q     <= rounding_mode;
            unpacked <= 1'b0;
            in_ready <= 1'b0;
            state    <= S_DIV;
          end
        end
        S_DIV: begin
          if (!unpacked) begin
            if (b_q[30:0] == '0) begin
              result      <= {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end else begin
              unpacked <= 1'b1;
              rem      <= {2'b01, a_q[MAN_W-1:0]};
              dsr      <= {1'b1, b_q[MAN_W-1:0]};
              quot     <= '0;
              cnt      <= CW'(ITER - 1);
            end
          end else begin
            quot <= {quot[ITER-2:0], ge};
            rem  <= rem_nx << 1;
            cnt  <= cnt - CW'(1);
            if (cnt == '0) begin
              state <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          result      <= {res_sign, rnd_exp, rnd_man};
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vectors plus randomized operands against a rational reference.
// Latency: checks ITER+2 edges for normal results, 1 edge for zero divisor.
// Backpressure: holds out_ready low in DONE and checks the result stays put.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [1:0]  rounding_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  fp_divider #(.ITER(27)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dividend      (dividend),
    .divisor       (divisor),
    .rounding_mode (rounding_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  // Reference: exact significand quotient from integer division, then round the rational value.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    logic        s;
    logic [63:0] ma, mb, num, q, r, sig, tail, half;
    int          e, sh;
    bit          above, tie, inexact, up;
    s = a[31] ^ b[31];
    if (b[30:0] == 31'd0) return {s, 8'hFF, 23'd0};
    ma  = {40'd0, 1'b1, a[22:0]};
    mb  = {40'd0, 1'b1, b[22:0]};
    num = ma << 26;
    q   = num / mb;
    r   = num % mb;
    e   = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (64'd1 << 26)) sh = 3;
    else begin
      sh = 2;
      e  = e - 1;
    end
    sig     = q >> sh;
    tail    = q & ((64'd1 << sh) - 64'd1);
    half    = 64'd1 << (sh - 1);
    above   = (tail > half) || (tail == half && r != 0);
    tie     = (tail == half) && (r == 0);
    inexact = (tail != 0) || (r != 0);
    case (m)
      2'b00:   up = above || (tie && sig[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = inexact && !s;
      default: up = inexact && s;
    endcase
    if (up) sig = sig + 64'd1;
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    return {s, e[7:0], sig[22:0]};
  endfunction

  // Issue one operation, measure latency, check result, then complete the output handshake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input logic [31:0] want, input logic want_dbz, input int want_lat);
    int lat;
    @(negedge clk);
    check({tag, "/in_ready_before"}, {31'd0, in_ready}, 32'd1);
    dividend      = a;
    divisor       = b;
    rounding_mode = m;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    dividend      = $urandom;
    divisor       = $urandom;
    rounding_mode = 2'($urandom_range(0, 3));
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(want_lat));
    check({tag, "/result"}, result, want);
    check({tag, "/dbz"}, {31'd0, div_by_zero}, {31'd0, want_dbz});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/out_valid_after"}, {31'd0, out_valid}, 32'd0);
    check({tag, "/in_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    logic [31:0] a, b, w;
    logic [1:0]  m;
    bit          z;

    // Reset state
    #12;
    check("rst/in_ready", {31'd0, in_ready}, 32'd1);
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/result", result, 32'd0);
    check("rst/dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_op("six_by_two",    32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 1'b0, 29);
    run_op("third_rne",     32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 1'b0, 29);
    run_op("third_rtz",     32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 1'b0, 29);
    run_op("neg_third_rdn", 32'hBF800000, 32'h40400000, 2'b11, 32'hBEAAAAAB, 1'b0, 29);
    run_op("neg_third_rup", 32'hBF800000, 32'h40400000, 2'b10, 32'hBEAAAAAA, 1'b0, 29);
    run_op("div_zero",      32'h3F800000, 32'h80000000, 2'b00, 32'hFF800000, 1'b1, 1);

    // Hold the result in DONE while in_valid pulses must be ignored
    @(negedge clk);
    dividend = 32'h40C00000; divisor = 32'h40000000; rounding_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("stall/result", result, 32'h40400000);
    held = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      dividend = $urandom;
      divisor  = $urandom;
      @(posedge clk);
      #1;
      check("stall/hold_result", result, held);
      check("stall/in_ready", {31'd0, in_ready}, 32'd0);
      check("stall/out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall/in_ready_after", {31'd0, in_ready}, 32'd1);

    // Leave div_by_zero and a non-zero result on the outputs, then reset mid-DIV
    run_op("div_zero_neg", 32'hBF800000, 32'h00000000, 2'b01, 32'hFF800000, 1'b1, 1);
    @(negedge clk);
    dividend = 32'h3F800000; divisor = 32'h40400000; rounding_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst/in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst/out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst/result", result, 32'd0);
    check("midrst/dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("midrst/no_stale_output", {31'd0, out_valid}, 32'd0);
    run_op("after_reset", 32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 1'b0, 29);

    // Randomized operands against the reference model
    for (int k = 0; k < 40; k++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
      z = ($urandom_range(0, 7) == 0);
      if (z) b = {1'($urandom_range(0, 1)), 31'd0};
      else   b = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
      m = 2'($urandom_range(0, 3));
      w = ref_div(a, b, m);
      run_op($sformatf("rand%0d", k), a, b, m, w, z, z ? 1 : 29);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
